// File: rtl/cached_mem_ctrl_pkg.sv
// Shared types and width helpers for the cached memory controller.
package cached_mem_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } state_t;

  // Number of index bits for a direct-mapped cache of the given line count
  function automatic int idx_width(input int lines);
    return $clog2(lines);
  endfunction

  // Tag bits left over once the index has been taken from the word address
  function automatic int tag_width(input int addr_w, input int lines);
    return addr_w - $clog2(lines);
  endfunction

endpackage

// File: rtl/cached_mem_ctrl_dm_cache_array.sv
// Direct-mapped cache storage: tag+data lines in a RAM with registered read,
// plus a valid-bit vector that can be cleared in a single cycle.
module dm_cache_array #(
  parameter int LINES  = 16,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear_all,
  input  logic              i_rd_en,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic              o_rd_valid,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  logic [DATA_W-1:0] i_wr_data
);

  logic [TAG_W+DATA_W-1:0] r_mem [LINES];
  logic [TAG_W+DATA_W-1:0] r_rd_line;
  logic [LINES-1:0]        r_valid;
  logic                    r_rd_valid;
  logic [LINES-1:0]        w_line_set;

  // One-hot decode of the line being written, used to set its valid bit
  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_line_sel
      assign w_line_set[gi] = i_wr_en && (i_wr_idx == IDX_W'(gi));
    end
  endgenerate

  // Valid bits: cleared by reset or flush, set when a line is written
  always_ff @(posedge clk) begin
    if (rst || i_clear_all) begin
      r_valid <= '0;
    end else begin
      r_valid <= r_valid | w_line_set;
    end
  end

  // Tag/data RAM: one write port and one registered read port
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= {i_wr_tag, i_wr_data};
    end
    if (i_rd_en) begin
      r_rd_line <= r_mem[i_rd_idx];
    end
  end

  // Valid bit read alongside the RAM so both arrive in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
    end else if (i_rd_en) begin
      r_rd_valid <= r_valid[i_rd_idx];
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_tag   = r_rd_line[TAG_W+DATA_W-1:DATA_W];
  assign o_rd_data  = r_rd_line[DATA_W-1:0];

endmodule

// File: rtl/cached_mem_ctrl.sv
// Write-through direct-mapped cache controller sitting between the pipeline
// MEM stage and a backing RAM. Holds the FSM, request latch, memory port and
// hit/miss counters; line storage lives in dm_cache_array.
module cached_mem_ctrl
  import cached_mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int LINES       = 16,
  parameter int WRITE_ALLOC = 1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int IDX_W = idx_width(LINES);
  localparam int TAG_W = tag_width(ADDR_W, LINES);

  state_t              r_state;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic                r_mem_req;
  logic                r_mem_write;
  logic [CNT_W-1:0]    r_hit_cnt;
  logic [CNT_W-1:0]    r_miss_cnt;

  logic                w_accept;
  logic                w_clear;
  logic                w_hit;
  logic                w_rd_valid;
  logic [TAG_W-1:0]    w_rd_tag;
  logic [DATA_W-1:0]   w_rd_data;
  logic [TAG_W-1:0]    w_req_tag;
  logic                w_wr_en;
  logic [DATA_W-1:0]   w_wr_data;

  // Flush only counts in IDLE and blocks acceptance in that same cycle
  assign req_ready = (r_state == IDLE) && !flush;
  assign w_accept  = req_valid && req_ready;
  assign w_clear   = flush && (r_state == IDLE);

  assign w_req_tag = r_addr[ADDR_W-1:IDX_W];
  assign w_hit     = w_rd_valid && (w_rd_tag == w_req_tag);

  // Lines are written by a write in LOOKUP (allocate or hit) or by a read fill
  assign w_wr_en   = ((r_state == LOOKUP) && r_write && ((WRITE_ALLOC != 0) || w_hit)) ||
                     ((r_state == MEM_RD) && mem_ack);
  assign w_wr_data = r_write ? r_wdata : mem_rdata;

  dm_cache_array #(
    .LINES  (LINES),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .i_clear_all (w_clear),
    .i_rd_en     (w_accept),
    .i_rd_idx    (req_addr[IDX_W-1:0]),
    .o_rd_valid  (w_rd_valid),
    .o_rd_tag    (w_rd_tag),
    .o_rd_data   (w_rd_data),
    .i_wr_en     (w_wr_en),
    .i_wr_idx    (r_addr[IDX_W-1:0]),
    .i_wr_tag    (w_req_tag),
    .i_wr_data   (w_wr_data)
  );

  // Controller FSM with registered response, memory strobes and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_req    <= 1'b0;
      r_mem_write  <= 1'b0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (r_write) begin
            r_mem_req   <= 1'b1;
            r_mem_write <= 1'b1;
            r_state     <= MEM_WR;
          end else if (w_hit) begin
            r_resp_rdata <= w_rd_data;
            r_resp_valid <= 1'b1;
            if (r_hit_cnt != {CNT_W{1'b1}}) begin
              r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            end
            r_state <= IDLE;
          end else begin
            if (r_miss_cnt != {CNT_W{1'b1}}) begin
              r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            end
            r_mem_req   <= 1'b1;
            r_mem_write <= 1'b0;
            r_state     <= MEM_RD;
          end
        end
        MEM_RD: begin
          if (mem_ack) begin
            r_resp_rdata <= mem_rdata;
            r_resp_valid <= 1'b1;
            r_mem_req    <= 1'b0;
            r_state      <= IDLE;
          end
        end
        MEM_WR: begin
          if (mem_ack) begin
            r_resp_valid <= 1'b1;
            r_mem_req    <= 1'b0;
            r_mem_write  <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The latched request drives the memory port, so it is stable during mem_req
  assign mem_req    = r_mem_req;
  assign mem_write  = r_mem_write;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign hit_cnt    = r_hit_cnt;
  assign miss_cnt   = r_miss_cnt;

endmodule

// File: tb/tb_cached_mem_ctrl.sv
// Directed testbench for cached_mem_ctrl. Three instances: defaults (0),
// WRITE_ALLOC=0 (1) and CNT_W=2 (2).
module tb_cached_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]        req_valid, req_ready, req_write, resp_valid, flush;
  logic [2:0]        mem_req, mem_write, mem_ack;
  logic [2:0][7:0]   req_addr, mem_addr;
  logic [2:0][31:0]  req_wdata, resp_rdata, mem_wdata, mem_rdata;
  logic [1:0][15:0]  hit_cnt, miss_cnt;
  logic [1:0]        hit_c2, miss_c2;

  int n_checks = 0;
  int n_fail   = 0;

  int          obs_bursts, obs_lat;
  logic        obs_got, obs_mw, obs_stable;
  logic [7:0]  obs_maddr;
  logic [31:0] obs_mwdata, obs_rdata;

  cached_mem_ctrl u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .flush(flush[0]),
    .mem_req(mem_req[0]), .mem_write(mem_write[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_ack(mem_ack[0]), .mem_rdata(mem_rdata[0]),
    .hit_cnt(hit_cnt[0]), .miss_cnt(miss_cnt[0])
  );

  cached_mem_ctrl #(.WRITE_ALLOC(0)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .flush(flush[1]),
    .mem_req(mem_req[1]), .mem_write(mem_write[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_ack(mem_ack[1]), .mem_rdata(mem_rdata[1]),
    .hit_cnt(hit_cnt[1]), .miss_cnt(miss_cnt[1])
  );

  cached_mem_ctrl #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]), .flush(flush[2]),
    .mem_req(mem_req[2]), .mem_write(mem_write[2]), .mem_addr(mem_addr[2]),
    .mem_wdata(mem_wdata[2]), .mem_ack(mem_ack[2]), .mem_rdata(mem_rdata[2]),
    .hit_cnt(hit_c2), .miss_cnt(miss_c2)
  );

  task automatic do_reset();
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    flush = '0; mem_ack = '0; mem_rdata = '0;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one request on instance d and act as the backing memory: ack after
  // ack_delay cycles of mem_req, returning mrdata. Bounded to 40 cycles.
  task automatic xact(input int d, input logic wr, input logic [7:0] addr,
                      input logic [31:0] wdata, input int ack_delay, input logic [31:0] mrdata);
    int   k;
    logic prev_req;
    obs_bursts = 0; obs_lat = 0; obs_got = 1'b0; obs_stable = 1'b1;
    obs_mw = 1'b0; obs_maddr = '0; obs_mwdata = '0; obs_rdata = '0;
    @(negedge clk);
    req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = addr; req_wdata[d] = wdata;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    k = 0; prev_req = 1'b0;
    for (int cyc = 1; cyc <= 40 && !obs_got; cyc++) begin
      @(negedge clk);
      mem_ack[d] = 1'b0;
      if (resp_valid[d]) begin
        obs_got = 1'b1; obs_lat = cyc; obs_rdata = resp_rdata[d];
      end else if (mem_req[d]) begin
        if (!prev_req) begin
          obs_bursts++; obs_mw = mem_write[d]; obs_maddr = mem_addr[d];
          obs_mwdata = mem_wdata[d]; k = 0;
        end else if (mem_addr[d] !== obs_maddr || mem_wdata[d] !== obs_mwdata || mem_write[d] !== obs_mw) begin
          obs_stable = 1'b0;
        end
        if (k == ack_delay) begin
          mem_ack[d] = 1'b1; mem_rdata[d] = mrdata;
        end
        k++;
      end
      prev_req = mem_req[d];
    end
    mem_ack[d] = 1'b0;
    $display("xact dut%0d wr=%0b addr=%02h wdata=%08h -> got=%0b lat=%0d rdata=%08h bursts=%0d",
             d, wr, addr, wdata, obs_got, obs_lat, obs_rdata, obs_bursts);
    n_checks++;
    if (obs_got !== 1'b1) begin n_fail++; $display("FAIL resp_timeout dut%0d addr=%02h: got=%0b required=1", d, addr, obs_got); end
    n_checks++;
    if (obs_stable !== 1'b1) begin n_fail++; $display("FAIL mem_port_stable dut%0d: got=%0b required=1", d, obs_stable); end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++; if (req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b required 1", req_ready[0]); end
    n_checks++; if (resp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %0b required 0", resp_valid[0]); end
    n_checks++; if (resp_rdata[0] !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata: got %h required 0", resp_rdata[0]); end
    n_checks++; if (mem_req[0] !== 1'b0 || mem_write[0] !== 1'b0) begin n_fail++; $display("FAIL reset_mem: got req=%0b wr=%0b required 0/0", mem_req[0], mem_write[0]); end
    n_checks++; if (hit_cnt[0] !== 16'd0 || miss_cnt[0] !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got hit=%0d miss=%0d required 0/0", hit_cnt[0], miss_cnt[0]); end
  endtask

  task automatic test_read_miss_hit();
    xact(0, 1'b0, 8'h05, 32'h0, 3, 32'hDEADBEEF);
    n_checks++; if (obs_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL miss_rdata: got %h required deadbeef", obs_rdata); end
    n_checks++; if (obs_bursts != 1 || obs_mw !== 1'b0 || obs_maddr !== 8'h05) begin n_fail++; $display("FAIL miss_memreq: got bursts=%0d wr=%0b addr=%h required 1/0/05", obs_bursts, obs_mw, obs_maddr); end
    n_checks++; if (miss_cnt[0] !== 16'd1) begin n_fail++; $display("FAIL miss_cnt1: got %0d required 1", miss_cnt[0]); end
    xact(0, 1'b0, 8'h05, 32'h0, 0, 32'h0BADF00D);
    n_checks++; if (obs_lat != 2) begin n_fail++; $display("FAIL hit_latency: got %0d required 2", obs_lat); end
    n_checks++; if (obs_bursts != 0) begin n_fail++; $display("FAIL hit_no_memreq: got %0d required 0", obs_bursts); end
    n_checks++; if (obs_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hit_rdata: got %h required deadbeef", obs_rdata); end
    n_checks++; if (hit_cnt[0] !== 16'd1 || miss_cnt[0] !== 16'd1) begin n_fail++; $display("FAIL hit_cnt1: got hit=%0d miss=%0d required 1/1", hit_cnt[0], miss_cnt[0]); end
  endtask

  task automatic test_same_index();
    int total;
    do_reset();
    total = 0;
    xact(0, 1'b0, 8'h05, 32'h0, 0, 32'hA5A5A5A5); total += obs_bursts;
    xact(0, 1'b0, 8'h15, 32'h0, 1, 32'hB5B5B5B5); total += obs_bursts;
    n_checks++; if (obs_rdata !== 32'hB5B5B5B5) begin n_fail++; $display("FAIL conflict_rdata15: got %h required b5b5b5b5", obs_rdata); end
    xact(0, 1'b0, 8'h05, 32'h0, 2, 32'hC5C5C5C5); total += obs_bursts;
    n_checks++; if (obs_rdata !== 32'hC5C5C5C5) begin n_fail++; $display("FAIL conflict_rdata05: got %h required c5c5c5c5", obs_rdata); end
    n_checks++; if (total != 3) begin n_fail++; $display("FAIL conflict_bursts: got %0d required 3", total); end
    n_checks++; if (miss_cnt[0] !== 16'd3 || hit_cnt[0] !== 16'd0) begin n_fail++; $display("FAIL conflict_cnt: got miss=%0d hit=%0d required 3/0", miss_cnt[0], hit_cnt[0]); end
  endtask

  task automatic test_write_alloc();
    do_reset();
    for (int d = 0; d < 2; d++) begin
      xact(d, 1'b1, 8'h22, 32'h12345678, 1, 32'hFFFFFFFF);
      n_checks++; if (obs_bursts != 1 || obs_mw !== 1'b1 || obs_maddr !== 8'h22 || obs_mwdata !== 32'h12345678) begin
        n_fail++; $display("FAIL write_mem dut%0d: got bursts=%0d wr=%0b addr=%h wdata=%h required 1/1/22/12345678", d, obs_bursts, obs_mw, obs_maddr, obs_mwdata);
      end
      n_checks++; if (miss_cnt[d] !== 16'd0 || hit_cnt[d] !== 16'd0) begin n_fail++; $display("FAIL write_uncounted dut%0d: got hit=%0d miss=%0d required 0/0", d, hit_cnt[d], miss_cnt[d]); end
    end
    xact(0, 1'b0, 8'h22, 32'h0, 0, 32'hFFFFFFFF);
    n_checks++; if (obs_bursts != 0 || obs_lat != 2 || obs_rdata !== 32'h12345678) begin n_fail++; $display("FAIL wa1_readback: got bursts=%0d lat=%0d rdata=%h required 0/2/12345678", obs_bursts, obs_lat, obs_rdata); end
    xact(1, 1'b0, 8'h22, 32'h0, 0, 32'h12345678);
    n_checks++; if (obs_bursts != 1 || miss_cnt[1] !== 16'd1) begin n_fail++; $display("FAIL wa0_readback_miss: got bursts=%0d miss=%0d required 1/1", obs_bursts, miss_cnt[1]); end
    // Line is now cached in the no-allocate instance: a write hit must update it
    xact(1, 1'b1, 8'h22, 32'hCAFE0001, 0, 32'h0);
    xact(1, 1'b0, 8'h22, 32'h0, 0, 32'hFFFFFFFF);
    n_checks++; if (obs_bursts != 0 || obs_rdata !== 32'hCAFE0001) begin n_fail++; $display("FAIL wa0_write_hit: got bursts=%0d rdata=%h required 0/cafe0001", obs_bursts, obs_rdata); end
  endtask

  task automatic test_flush();
    xact(0, 1'b0, 8'h05, 32'h0, 0, 32'h11110005);
    xact(0, 1'b0, 8'h05, 32'h0, 0, 32'h0);
    n_checks++; if (obs_bursts != 0) begin n_fail++; $display("FAIL flush_precached: got bursts=%0d required 0", obs_bursts); end
    @(negedge clk);
    flush[0] = 1'b1; req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 8'h05;
    #1;
    n_checks++; if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %0b required 0", req_ready[0]); end
    @(posedge clk); #1;
    flush[0] = 1'b0; req_valid[0] = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL flush_not_accepted: got ready=%0b resp=%0b required 1/0", req_ready[0], resp_valid[0]); end
    xact(0, 1'b0, 8'h05, 32'h0, 0, 32'h22220005);
    n_checks++; if (obs_bursts != 1 || obs_rdata !== 32'h22220005) begin n_fail++; $display("FAIL flush_miss: got bursts=%0d rdata=%h required 1/22220005", obs_bursts, obs_rdata); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    logic any_resp;
    do_reset();
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 8'h30;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = mem_req[0];
    end
    $display("xact dut0 rd addr=30 mem_req=%0b (reset mid-transaction)", seen);
    n_checks++; if (seen !== 1'b1 || miss_cnt[0] !== 16'd1) begin n_fail++; $display("FAIL rstmid_memrd: got mem_req=%0b miss=%0d required 1/1", seen, miss_cnt[0]); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_req[0] !== 1'b0 || resp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_outputs: got mem_req=%0b resp=%0b required 0/0", mem_req[0], resp_valid[0]); end
    n_checks++; if (miss_cnt[0] !== 16'd0 || hit_cnt[0] !== 16'd0) begin n_fail++; $display("FAIL rstmid_cnt: got miss=%0d hit=%0d required 0/0", miss_cnt[0], hit_cnt[0]); end
    rst = 1'b0;
    #1;
    n_checks++; if (req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %0b required 1", req_ready[0]); end
    any_resp = 1'b0;
    repeat (5) begin
      @(negedge clk);
      any_resp = any_resp | resp_valid[0] | mem_req[0];
    end
    n_checks++; if (any_resp !== 1'b0) begin n_fail++; $display("FAIL rstmid_abandoned: got activity=%0b required 0", any_resp); end
  endtask

  task automatic test_saturate();
    do_reset();
    xact(2, 1'b0, 8'h05, 32'h0, 1, 32'h55555555);
    for (int i = 0; i < 5; i++) begin
      xact(2, 1'b0, 8'h05, 32'h0, 0, 32'h0);
      n_checks++; if (obs_rdata !== 32'h55555555 || obs_bursts != 0) begin n_fail++; $display("FAIL sat_hit%0d: got rdata=%h bursts=%0d required 55555555/0", i, obs_rdata, obs_bursts); end
    end
    n_checks++; if (hit_c2 !== 2'd3 || miss_c2 !== 2'd1) begin n_fail++; $display("FAIL sat_cnt: got hit=%0d miss=%0d required 3/1", hit_c2, miss_c2); end
  endtask

  initial begin
    test_reset();
    test_read_miss_hit();
    test_same_index();
    test_write_alloc();
    test_flush();
    test_reset_mid();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
